// File: rtl/pulseox_pkg.sv
// Shared types and constants for the pulse-oximeter FFT back end.
//   FFT_W / DATA_W : packed complex bin width / per-component signed width
//   COMP_W / HR_W  : magnitude and BPM/bin-index output widths
//   state_e        : FSM state encoding shared by the collector and result sequencer
//   bpm_scale()    : (bin * mult) >> 8, saturated to HR_W bits
package pulseox_pkg;
    localparam int FFT_W  = 44;
    localparam int DATA_W = 22;
    localparam int COMP_W = 24;
    localparam int HR_W   = 10;
    localparam int BIN_W  = 10;
    localparam int PROD_W = 20;

    localparam int N_BINS_DEF     = 1024;
    localparam int HR_BIN_MIN_DEF = 16;
    localparam int HR_BIN_MAX_DEF = 86;
    localparam int BPM_MULT_DEF   = 625;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_SCALE,
        ST_OUTPUT,
        ST_WAIT_LOW
    } state_e;

    function automatic logic [HR_W-1:0] bpm_scale(input logic [BIN_W-1:0] bin,
                                                  input logic [PROD_W-1:0] mult);
        logic [PROD_W-1:0] shifted;
        shifted = PROD_W'(bin * mult) >> 8;
        return (|shifted[PROD_W-1:HR_W]) ? {HR_W{1'b1}} : shifted[HR_W-1:0];
    endfunction
endpackage

// File: rtl/fft_mag_l1.sv
// Two-stage L1 magnitude pipeline: stage 1 takes |re| and |im|, stage 2 sums them.
//   valid_in/idx  : bin qualifier and bin index, delayed alongside the data
//   data          : [43:22] signed real, [21:0] signed imag
//   valid_out/mag/idx_out : result two cycles after the input
module fft_mag_l1
    import pulseox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [FFT_W-1:0]  data,
    input  logic [BIN_W-1:0]  idx,
    output logic              valid_out,
    output logic [COMP_W-1:0] mag,
    output logic [BIN_W-1:0]  idx_out
);
    logic [DATA_W-1:0] re, im;
    logic [DATA_W-1:0] abs_re_d, abs_im_d, abs_re_q, abs_im_q;
    logic [COMP_W-1:0] mag_d, mag_q;
    logic [BIN_W-1:0]  idx1_q, idx2_q;
    logic              v1_q, v2_q;

    assign re = data[FFT_W-1:DATA_W];
    assign im = data[DATA_W-1:0];

    // Two's complement negate in unsigned DATA_W bits: -2^21 maps to 2^21,
    // which still fits because the result is treated as unsigned.
    always_comb begin
        abs_re_d = re[DATA_W-1] ? (~re + DATA_W'(1)) : re;
        abs_im_d = im[DATA_W-1] ? (~im + DATA_W'(1)) : im;
        mag_d    = COMP_W'(abs_re_q) + COMP_W'(abs_im_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            abs_re_q <= '0;
            abs_im_q <= '0;
            idx1_q   <= '0;
            idx2_q   <= '0;
            mag_q    <= '0;
        end else begin
            v1_q     <= valid_in;
            abs_re_q <= abs_re_d;
            abs_im_q <= abs_im_d;
            idx1_q   <= idx;
            v2_q     <= v1_q;
            idx2_q   <= idx1_q;
            mag_q    <= mag_d;
        end
    end

    assign valid_out = v2_q;
    assign mag       = mag_q;
    assign idx_out   = idx2_q;
endmodule

// File: rtl/fft_hr_peak_extract.sv
// Reduces one streamed FFT frame to DC magnitude, peak in-band AC magnitude and HR in BPM.
//   clk, rst      : clock, asynchronous active-high reset
//   fft_sync      : high while a bin is on fft_data; a frame is one contiguous high run
//   fft_data      : [43:22] signed real, [21:0] signed imag
//   ac_comp/dc_comp/hr_bpm/peak_bin : registered, held results
//   new_comp_dv   : one-cycle pulse when the results update
//   frame_err     : one-cycle pulse when a frame ends short
// Collection and result sequencing are separate FSMs so a new frame may start
// (after a single sync-low cycle) while the previous one is still draining.
module fft_hr_peak_extract
    import pulseox_pkg::*;
#(
    parameter int N_BINS     = N_BINS_DEF,
    parameter int HR_BIN_MIN = HR_BIN_MIN_DEF,
    parameter int HR_BIN_MAX = HR_BIN_MAX_DEF,
    parameter int BPM_MULT   = BPM_MULT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_sync,
    input  logic [FFT_W-1:0]  fft_data,
    output logic [COMP_W-1:0] ac_comp,
    output logic [COMP_W-1:0] dc_comp,
    output logic [HR_W-1:0]   hr_bpm,
    output logic [HR_W-1:0]   peak_bin,
    output logic              new_comp_dv,
    output logic              frame_err
);
    state_e            cst_q, cst_d, res_q, res_d;
    logic [BIN_W-1:0]  bin_cnt_q, bin_cnt_d;
    logic              sync_prev_q, sync_prev_d;
    logic              drain_cnt_q, drain_cnt_d;
    logic [COMP_W-1:0] max_q, max_d, dc_lat_q, dc_lat_d;
    logic [BIN_W-1:0]  pk_q, pk_d;
    logic [COMP_W-1:0] ac_q, ac_d, dc_q, dc_d;
    logic [HR_W-1:0]   hr_q, hr_d, peak_q, peak_d;
    logic              dv_q, dv_d, err_q, err_d, err_pend_q, err_pend_d;

    logic              in_vld, frame_done, frame_abort;
    logic [BIN_W-1:0]  in_idx;
    logic              m_vld;
    logic [COMP_W-1:0] m_mag;
    logic [BIN_W-1:0]  m_idx;

    fft_mag_l1 u_mag (
        .clk      (clk),
        .rst      (rst),
        .valid_in (in_vld),
        .data     (fft_data),
        .idx      (in_idx),
        .valid_out(m_vld),
        .mag      (m_mag),
        .idx_out  (m_idx)
    );

    // Frame collector. The rising-edge cycle itself carries bin 0.
    always_comb begin
        cst_d       = cst_q;
        bin_cnt_d   = bin_cnt_q;
        sync_prev_d = fft_sync;
        in_vld      = 1'b0;
        in_idx      = bin_cnt_q;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (cst_q)
            ST_IDLE: begin
                if (fft_sync && !sync_prev_q) begin
                    in_vld    = 1'b1;
                    in_idx    = '0;
                    bin_cnt_d = BIN_W'(1);
                    cst_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (fft_sync) begin
                    // Upper half of the spectrum is the mirror image; never examined.
                    in_vld = (bin_cnt_q < BIN_W'(N_BINS / 2));
                    if (bin_cnt_q == BIN_W'(N_BINS - 1)) begin
                        frame_done = 1'b1;
                        cst_d      = ST_WAIT_LOW;
                    end else begin
                        bin_cnt_d = bin_cnt_q + BIN_W'(1);
                    end
                end else begin
                    frame_abort = 1'b1;
                    cst_d       = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                // Any sync still high here is the tail of the finished frame.
                if (!fft_sync) cst_d = ST_IDLE;
            end
            default: cst_d = ST_IDLE;
        endcase
    end

    // Running peak search on the pipeline output. Bin 0 of a frame re-arms the
    // search, so stale bins from an aborted frame are harmless.
    always_comb begin
        max_d    = max_q;
        pk_d     = pk_q;
        dc_lat_d = dc_lat_q;
        if (m_vld) begin
            if (m_idx == '0) begin
                dc_lat_d = m_mag;
                max_d    = '0;
                pk_d     = BIN_W'(HR_BIN_MIN);
            end else if (m_idx >= BIN_W'(HR_BIN_MIN) && m_idx <= BIN_W'(HR_BIN_MAX) &&
                         m_mag > max_q) begin
                max_d = m_mag;
                pk_d  = m_idx;
            end
        end
    end

    // Result sequencer: two drain cycles let the last bin leave the magnitude
    // pipeline; SCALE loads the output registers so dv shows up in OUTPUT.
    always_comb begin
        res_d       = res_q;
        drain_cnt_d = drain_cnt_q;
        ac_d        = ac_q;
        dc_d        = dc_q;
        hr_d        = hr_q;
        peak_d      = peak_q;
        dv_d        = 1'b0;
        case (res_q)
            ST_IDLE: begin
                if (frame_done) begin
                    res_d       = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q) res_d = ST_SCALE;
                else             drain_cnt_d = 1'b1;
            end
            ST_SCALE: begin
                ac_d   = max_q;
                dc_d   = dc_lat_q;
                peak_d = HR_W'(pk_q);
                hr_d   = bpm_scale(pk_q, PROD_W'(BPM_MULT));
                dv_d   = 1'b1;
                res_d  = ST_OUTPUT;
            end
            ST_OUTPUT: res_d = ST_IDLE;
            default:   res_d = ST_IDLE;
        endcase
        // An abort colliding with a result pulse is deferred one cycle.
        err_d      = (frame_abort | err_pend_q) & ~dv_d;
        err_pend_d = (frame_abort | err_pend_q) & dv_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cst_q       <= ST_IDLE;
            res_q       <= ST_IDLE;
            bin_cnt_q   <= '0;
            // Starts high so a sync already asserted out of reset is not a new frame.
            sync_prev_q <= 1'b1;
            drain_cnt_q <= 1'b0;
            max_q       <= '0;
            pk_q        <= BIN_W'(HR_BIN_MIN);
            dc_lat_q    <= '0;
            ac_q        <= '0;
            dc_q        <= '0;
            hr_q        <= '0;
            peak_q      <= '0;
            dv_q        <= 1'b0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            cst_q       <= cst_d;
            res_q       <= res_d;
            bin_cnt_q   <= bin_cnt_d;
            sync_prev_q <= sync_prev_d;
            drain_cnt_q <= drain_cnt_d;
            max_q       <= max_d;
            pk_q        <= pk_d;
            dc_lat_q    <= dc_lat_d;
            ac_q        <= ac_d;
            dc_q        <= dc_d;
            hr_q        <= hr_d;
            peak_q      <= peak_d;
            dv_q        <= dv_d;
            err_q       <= err_d;
            err_pend_q  <= err_pend_d;
        end
    end

    assign ac_comp     = ac_q;
    assign dc_comp     = dc_q;
    assign hr_bpm      = hr_q;
    assign peak_bin    = peak_q;
    assign new_comp_dv = dv_q;
    assign frame_err   = err_q;
endmodule
